// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the iteration-counter width helper.
package mult_div_unit_pkg;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int unsigned iter_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_div_unit_iter.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. Purely combinational.
module mdu_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}.
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Divide: acc = {remainder, dividend bits then quotient bits}.
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd};
    q_bit  = 1'b0;
    if (is_div) begin
      q_bit    = ~diff[WIDTH];
      acc_next = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO; WIDTH iterations plus one
// sign-fix cycle behind a start/busy/done handshake.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned       IterW    = iter_w(WIDTH);
  localparam logic [IterW-1:0]  LastIter = IterW'(WIDTH - 1);

  state_e             state_q;
  logic [IterW-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic               q_bit;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic               is_div_q;
  logic               neg_q;
  logic               neg_rem_q;
  logic               dz_q;

  logic               is_arith;
  logic               is_signed;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;
  logic [WIDTH-1:0]   raw_a;

  mdu_iter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div  (is_div_q),
    .acc     (acc_q),
    .opnd    (opb_q),
    .acc_next(acc_next),
    .q_bit   (q_bit)
  );

  always_comb begin
    is_arith  = ~op[2];
    is_signed = ~op[0];
    sign_a    = is_signed & OperandA[WIDTH-1];
    sign_b    = is_signed & OperandB[WIDTH-1];
    abs_a     = sign_a ? -OperandA : OperandA;
    abs_b     = sign_b ? -OperandB : OperandB;
  end

  always_comb begin
    prod  = neg_q ? -acc_q : acc_q;
    quo   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rmd   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    // Reconstructs the dividend exactly as presented, most-negative included.
    raw_a = neg_rem_q ? -opa_q : opa_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      is_div_q    <= 1'b0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      HI          <= '0;
      LO          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (is_arith) begin
              opa_q     <= abs_a;
              opb_q     <= abs_b;
              acc_q     <= {{WIDTH{1'b0}}, abs_a};
              is_div_q  <= op[1];
              neg_q     <= sign_a ^ sign_b;
              neg_rem_q <= sign_a;
              dz_q      <= op[1] & (OperandB == '0);
              cnt_q     <= '0;
              busy      <= 1'b1;
              state_q   <= StCalc;
            end else if (op == OpMthi) begin
              HI   <= OperandA;
              done <= 1'b1;
            end else if (op == OpMtlo) begin
              LO   <= OperandA;
              done <= 1'b1;
            end
          end
        end
        StCalc: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIter) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          if (!is_div_q) begin
            HI <= prod[2*WIDTH-1:WIDTH];
            LO <= prod[WIDTH-1:0];
          end else if (dz_q) begin
            HI          <= raw_a;
            LO          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            HI <= rmd;
            LO <= quo;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
